// File: rtl/spike_rate_encoder.sv
// Spike rate encoder: converts a small set of stored pixel intensities into
// Bernoulli-style spike trains, one LFSR per channel, for a fixed number of
// timesteps per presentation. Also clears downstream neuron accumulators
// before each presentation and signals completion with a one-cycle pulse.
module spike_rate_encoder #(
    parameter int          NUM_INPUTS  = 4,
    parameter int          PIXEL_WIDTH = 8,
    parameter int          NUM_STEPS   = 16,
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [PIXEL_WIDTH-1:0] mem_din,
    input  logic                   mem_wen,
    output logic [PIXEL_WIDTH-1:0] mem_dout,
    output logic [NUM_INPUTS-1:0]  spike_out,
    output logic                   spike_valid,
    output logic                   neuron_rst,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned NI = NUM_INPUTS;

    // Comparison width: wide enough for both the pixel and the 16-bit LFSR,
    // so the LFSR is zero-extended when pixels are wider than 16 bits.
    localparam int unsigned CW = (PIXEL_WIDTH > 16) ? PIXEL_WIDTH : 16;
    localparam logic [CW-1:0] LFSR_MASK = CW'({PIXEL_WIDTH{1'b1}});
    localparam logic [15:0] LAST_STEP = 16'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]            step;
    logic                   last_step;
    logic [PIXEL_WIDTH-1:0] pixel [NUM_INPUTS];
    logic [15:0]            lfsr  [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]  spike_next;
    logic [PIXEL_WIDTH-1:0] read_data;

    function automatic logic [15:0] seed_of(input int unsigned ch);
        return LFSR_SEED ^ 16'(ch + 1);
    endfunction

    // Fibonacci LFSR, taps 16,14,13,11 (bits 0,2,3,5 in right-shift form).
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    assign last_step  = (step == LAST_STEP);
    assign busy       = (state != IDLE);
    assign neuron_rst = (state == CLEAR);
    assign done       = (state == DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start only matters in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Timestep counter: counts RUN cycles, returns to zero on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= '0;
        end else if (state == RUN) begin
            step <= last_step ? '0 : step + 16'd1;
        end else begin
            step <= '0;
        end
    end

    // Per-channel LFSRs: reseeded when a presentation starts, stepped in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NI; i++) lfsr[i] <= seed_of(i);
        end else if (state == IDLE && start) begin
            for (int unsigned i = 0; i < NI; i++) lfsr[i] <= seed_of(i);
        end else if (state == RUN) begin
            for (int unsigned i = 0; i < NI; i++) lfsr[i] <= lfsr_step(lfsr[i]);
        end
    end

    // Spike decision per channel; full-scale pixels always fire.
    always_comb begin
        spike_next = '0;
        for (int unsigned i = 0; i < NI; i++) begin
            if (pixel[i] == '1) begin
                spike_next[i] = 1'b1;
            end else begin
                spike_next[i] = CW'(pixel[i]) > (CW'(lfsr[i]) & LFSR_MASK);
            end
        end
    end

    // Registered spike outputs, zero outside valid timesteps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_out   <= '0;
            spike_valid <= 1'b0;
        end else if (state == RUN) begin
            spike_out   <= spike_next;
            spike_valid <= 1'b1;
        end else begin
            spike_out   <= '0;
            spike_valid <= 1'b0;
        end
    end

    // Pixel registers: writable only while idle so a presentation is stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NI; i++) pixel[i] <= '0;
        end else if (mem_wen && state == IDLE) begin
            for (int unsigned i = 0; i < NI; i++) begin
                if (mem_addr == ADDR_WIDTH'(i)) pixel[i] <= mem_din;
            end
        end
    end

    // Read mux; out-of-range addresses read as zero.
    always_comb begin
        read_data = '0;
        for (int unsigned i = 0; i < NI; i++) begin
            if (mem_addr == ADDR_WIDTH'(i)) read_data = pixel[i];
        end
    end

    // Registered read port (old value on a same-cycle write).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_dout <= '0;
        end else begin
            mem_dout <= read_data;
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Self-checking bench for spike_rate_encoder: directed steps plus randomized
// pixel sets, checked against an arithmetic LFSR/spike reference model.
module tb_spike_rate_encoder;

    localparam int SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] mem_addr = '0;
    logic [7:0] mem_din = '0;
    logic       mem_wen = 1'b0;

    logic [7:0] dout_a, dout_b;
    logic [3:0] so_a, so_b;
    logic       sv_a, sv_b, nr_a, nr_b, busy_a, busy_b, done_a, done_b;

    // selected instance for the presentation task
    int         sel = 0;
    logic [3:0] so;
    logic       sv, nr, bz, dn;
    assign so = sel ? so_b   : so_a;
    assign sv = sel ? sv_b   : sv_a;
    assign nr = sel ? nr_b   : nr_a;
    assign bz = sel ? busy_b : busy_a;
    assign dn = sel ? done_b : done_a;

    int checks = 0;
    int failures = 0;

    int unsigned px [4];
    logic [3:0]  cap [$];
    logic [3:0]  prev [$];

    always #5 clk = ~clk;

    spike_rate_encoder #(.NUM_INPUTS(4), .PIXEL_WIDTH(8), .NUM_STEPS(16),
                         .ADDR_WIDTH(8), .LFSR_SEED(16'hACE1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(dout_a),
        .spike_out(so_a), .spike_valid(sv_a), .neuron_rst(nr_a),
        .busy(busy_a), .done(done_a));

    spike_rate_encoder #(.NUM_INPUTS(4), .PIXEL_WIDTH(8), .NUM_STEPS(1),
                         .ADDR_WIDTH(8), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_wen(mem_wen), .mem_dout(dout_b),
        .spike_out(so_b), .spike_valid(sv_b), .neuron_rst(nr_b),
        .busy(busy_b), .done(done_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: x^16+x^14+x^13+x^11+1 Fibonacci LFSR in plain integer arithmetic.
    function automatic int unsigned lfsr_next(input int unsigned l);
        int unsigned fb;
        fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return ((l >> 1) | (fb << 15)) & 32'hFFFF;
    endfunction

    // Expected spike vector at timestep k for the current pixel set.
    function automatic logic [3:0] model_step(input int k);
        logic [3:0] r;
        int unsigned l;
        for (int ch = 0; ch < 4; ch++) begin
            l = (SEED ^ (ch + 1)) & 32'hFFFF;
            for (int s = 0; s < k; s++) l = lfsr_next(l);
            if (px[ch] == 255) r[ch] = 1'b1;
            else r[ch] = (px[ch] > (l & 255));
        end
        return r;
    endfunction

    task automatic write_px(input int a, input int unsigned v);
        @(negedge clk);
        mem_addr = 8'(a); mem_din = 8'(v); mem_wen = 1'b1;
        @(negedge clk);
        mem_wen = 1'b0;
        if (a < 4) px[a] = v;
    endtask

    task automatic read_check(input string tag, input int a, input int unsigned exp);
        @(negedge clk);
        mem_addr = 8'(a);
        @(negedge clk);
        chk(tag, 32'(dout_a), exp);
    endtask

    // One presentation on the selected instance; inject_at >= 0 drives a write
    // of 77 to addr 0 and a start pulse at that observation index.
    task automatic present(input string tag, input int ns, input int inject_at);
        int n_valid, n_busy, n_nrst, n_done, first_v, last_v, done_idx, nrst_idx, bad_zero;
        n_valid = 0; n_busy = 0; n_nrst = 0; n_done = 0; bad_zero = 0;
        first_v = -1; last_v = -1; done_idx = -1; nrst_idx = -1;
        cap.delete();
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        for (int idx = 0; idx < ns + 8; idx++) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0; mem_wen = 1'b0;
            if (bz) n_busy++;
            if (nr) begin n_nrst++; if (nrst_idx < 0) nrst_idx = idx; end
            if (dn) begin n_done++; if (done_idx < 0) done_idx = idx; end
            if (sv) begin
                n_valid++;
                if (first_v < 0) first_v = idx;
                last_v = idx;
                cap.push_back(so);
            end else if (so != 4'b0) begin
                bad_zero++;
            end
            if (idx == inject_at) begin
                mem_addr = 8'd0; mem_din = 8'd77; mem_wen = 1'b1;
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
        end
        chk({tag, "_nrst_cnt"}, n_nrst, 1);
        chk({tag, "_nrst_idx"}, nrst_idx, 0);
        chk({tag, "_valid_cnt"}, n_valid, ns);
        chk({tag, "_valid_first"}, first_v, 2);
        chk({tag, "_valid_last"}, last_v, ns + 1);
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_done_idx"}, done_idx, ns + 1);
        chk({tag, "_busy_cnt"}, n_busy, ns + 2);
        chk({tag, "_idle_zero"}, bad_zero, 0);
        for (int k = 0; k < ns; k++) begin
            chk($sformatf("%s_spk%0d", tag, k),
                (k < cap.size()) ? 32'(cap[k]) : 32'hDEAD, 32'(model_step(k)));
        end
    endtask

    function automatic int ch_count(input int ch);
        int c = 0;
        foreach (cap[k]) c += cap[k][ch];
        return c;
    endfunction

    initial begin
        int exp2;
        for (int i = 0; i < 4; i++) px[i] = 0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_valid", sv_a, 0);
        chk("rst_spike", so_a, 0);
        chk("rst_nrst", nr_a, 0);
        chk("rst_dout", dout_a, 0);
        chk("rst_b_busy", busy_b, 0);
        rst = 1'b0;

        // pixel write / readback
        write_px(0, 0); write_px(1, 255); write_px(2, 128); write_px(3, 255);
        read_check("rd0", 0, 0);
        read_check("rd1", 1, 255);
        read_check("rd2", 2, 128);
        read_check("rd3", 3, 255);
        read_check("rd9", 9, 0);

        // same-cycle write returns old data, then new data
        @(negedge clk);
        mem_addr = 8'd1; mem_din = 8'd5; mem_wen = 1'b1;
        @(negedge clk);
        mem_wen = 1'b0;
        chk("rw_old", dout_a, 255);
        @(negedge clk);
        chk("rw_new", dout_a, 5);
        write_px(1, 255);

        // main presentation
        sel = 0;
        present("p16", 16, -1);
        chk("p16_ch0", ch_count(0), 0);
        chk("p16_ch1", ch_count(1), 16);
        chk("p16_ch3", ch_count(3), 16);
        exp2 = 0;
        for (int k = 0; k < 16; k++) exp2 += model_step(k)[2];
        chk("p16_ch2", ch_count(2), exp2);
        prev = cap;

        // repeat is deterministic
        present("rep", 16, -1);
        for (int k = 0; k < 16; k++)
            chk($sformatf("rep_same%0d", k), 32'(cap[k]), 32'(prev[k]));

        // write and start while running are ignored
        present("inj", 16, 4);
        read_check("inj_px0", 0, 0);
        read_check("inj_px1", 1, 255);

        // randomized pixel sets
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 4; i++) begin
                int unsigned v;
                v = $urandom_range(0, 255);
                if ($urandom_range(0, 5) == 0) v = 255;
                if ($urandom_range(0, 5) == 0) v = 0;
                write_px(i, v);
            end
            read_check($sformatf("rnd%0d_rd", t), t, px[t]);
            present($sformatf("rnd%0d", t), 16, -1);
        end

        // asynchronous reset mid-run
        write_px(1, 255);
        @(negedge clk);
        mem_addr = 8'd1;
        @(negedge clk);
        start_a = 1'b1;
        for (int idx = 0; idx < 7; idx++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        chk("mid_busy_pre", busy_a, 1);
        rst = 1'b1;
        #1;
        chk("ar_busy", busy_a, 0);
        chk("ar_done", done_a, 0);
        chk("ar_valid", sv_a, 0);
        chk("ar_spike", so_a, 0);
        chk("ar_nrst", nr_a, 0);
        chk("ar_dout", dout_a, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) px[i] = 0;
        for (int i = 0; i < 4; i++) read_check($sformatf("ar_px%0d", i), i, 0);
        for (int i = 0; i < 4; i++) write_px(i, $urandom_range(1, 254));
        present("post_rst", 16, -1);

        // single-step instance
        sel = 1;
        for (int i = 0; i < 4; i++) write_px(i, $urandom_range(0, 255));
        write_px(1, 255);
        write_px(0, 0);
        present("ns1", 1, -1);
        chk("ns1_ch1", ch_count(1), 1);
        chk("ns1_ch0", ch_count(0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
